// File: rtl/dma_stream_responder.sv
// DMA port responder: throttled read stream served from a preloadable data RAM,
// and a throttled write sink that captures engine beats into a debug-readable result RAM.
module dma_stream_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int THROTTLE   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_load,
  input  logic [1:0]            cfg_mode,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [ADDR_WIDTH-1:0] cfg_window,
  input  logic [ADDR_WIDTH-1:0] cfg_wbase,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] ob_data,
  output logic                  ob_we,
  input  logic                  wr_en,
  output logic                  ib_re,
  input  logic [DATA_WIDTH-1:0] ib_data,
  input  logic                  ib_valid,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic [CNT_WIDTH-1:0]  rd_beats,
  output logic [CNT_WIDTH-1:0]  wr_beats
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PH_W  = (THROTTLE > 1) ? $clog2(THROTTLE) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(THROTTLE - 1);

  typedef enum logic [1:0] {
    MODE_LINEAR = 2'd0,
    MODE_WRAP   = 2'd1,
    MODE_SLIDE  = 2'd2,
    MODE_RSVD   = 2'd3
  } mode_e;

  logic [DATA_WIDTH-1:0] data_mem   [DEPTH];
  logic [DATA_WIDTH-1:0] result_mem [DEPTH];

  mode_e                 mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, window_q, window_d, wbase_q, wbase_d;
  logic [ADDR_WIDTH-1:0] rptr_q, rptr_d, win_start_q, win_start_d, wptr_q, wptr_d;
  logic [PH_W-1:0]       rphase_q, rphase_d, wphase_q, wphase_d;
  logic [CNT_WIDTH-1:0]  rd_beats_q, rd_beats_d, wr_beats_q, wr_beats_d;
  logic                  ob_we_q, ob_we_d, ib_re_q, ib_re_d;
  logic [DATA_WIDTH-1:0] ob_data_q, dbg_data_q;

  logic                  rd_fire, wr_fire, capture;
  logic [ADDR_WIDTH-1:0] wrap_last, slide_last;

  always_comb begin
    rd_fire = rd_en && !cfg_load && (rphase_q == PH_LAST);
    wr_fire = wr_en && !cfg_load && (wphase_q == PH_LAST);
    capture = ib_re_q && ib_valid && !cfg_load;
    // A zero window wraps to base-1, i.e. a full DEPTH-long window.
    wrap_last  = base_q + window_q - ADDR_WIDTH'(1);
    slide_last = win_start_q + window_q - ADDR_WIDTH'(1);

    mode_d      = mode_q;
    base_d      = base_q;
    window_d    = window_q;
    wbase_d     = wbase_q;
    rptr_d      = rptr_q;
    win_start_d = win_start_q;
    wptr_d      = wptr_q;
    rphase_d    = rphase_q;
    wphase_d    = wphase_q;
    rd_beats_d  = rd_beats_q;
    wr_beats_d  = wr_beats_q;
    ob_we_d     = rd_fire;
    ib_re_d     = wr_fire;

    if (cfg_load) begin
      mode_d      = mode_e'(cfg_mode);
      base_d      = cfg_base;
      window_d    = cfg_window;
      wbase_d     = cfg_wbase;
      rptr_d      = cfg_base;
      win_start_d = cfg_base;
      wptr_d      = cfg_wbase;
      rphase_d    = '0;
      wphase_d    = '0;
      rd_beats_d  = '0;
      wr_beats_d  = '0;
    end else begin
      if (rd_en)
        rphase_d = (rphase_q == PH_LAST) ? '0 : rphase_q + PH_W'(1);
      if (wr_en)
        wphase_d = (wphase_q == PH_LAST) ? '0 : wphase_q + PH_W'(1);

      if (rd_fire) begin
        rd_beats_d = (rd_beats_q == '1) ? rd_beats_q : rd_beats_q + CNT_WIDTH'(1);
        unique case (mode_q)
          MODE_WRAP:
            rptr_d = (rptr_q == wrap_last) ? base_q : rptr_q + ADDR_WIDTH'(1);
          MODE_SLIDE: begin
            if (rptr_q == slide_last) begin
              rptr_d      = win_start_q + ADDR_WIDTH'(1);
              win_start_d = win_start_q + ADDR_WIDTH'(1);
            end else begin
              rptr_d = rptr_q + ADDR_WIDTH'(1);
            end
          end
          default:
            rptr_d = rptr_q + ADDR_WIDTH'(1);
        endcase
      end

      if (capture) begin
        wptr_d     = wptr_q + ADDR_WIDTH'(1);
        wr_beats_d = (wr_beats_q == '1) ? wr_beats_q : wr_beats_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= MODE_LINEAR;
      base_q      <= '0;
      window_q    <= '0;
      wbase_q     <= '0;
      rptr_q      <= '0;
      win_start_q <= '0;
      wptr_q      <= '0;
      rphase_q    <= '0;
      wphase_q    <= '0;
      rd_beats_q  <= '0;
      wr_beats_q  <= '0;
      ob_we_q     <= 1'b0;
      ib_re_q     <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      base_q      <= base_d;
      window_q    <= window_d;
      wbase_q     <= wbase_d;
      rptr_q      <= rptr_d;
      win_start_q <= win_start_d;
      wptr_q      <= wptr_d;
      rphase_q    <= rphase_d;
      wphase_q    <= wphase_d;
      rd_beats_q  <= rd_beats_d;
      wr_beats_q  <= wr_beats_d;
      ob_we_q     <= ob_we_d;
      ib_re_q     <= ib_re_d;
    end
  end

  // RAM arrays keep their contents across reset; only the read registers clear.
  always_ff @(posedge clk) begin
    if (ld_we)
      data_mem[ld_addr] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      ob_data_q <= '0;
    else if (rd_fire)
      ob_data_q <= data_mem[rptr_q];
  end

  always_ff @(posedge clk) begin
    if (capture && !rst)
      result_mem[wptr_q] <= ib_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      dbg_data_q <= '0;
    else
      dbg_data_q <= result_mem[dbg_addr];
  end

  assign ob_data  = ob_data_q;
  assign ob_we    = ob_we_q;
  assign ib_re    = ib_re_q;
  assign dbg_data = dbg_data_q;
  assign rd_beats = rd_beats_q;
  assign wr_beats = wr_beats_q;

endmodule

// File: tb/tb_dma_stream_responder.sv
// Scoreboard bench: a closed-form reference model predicts beats, pops and RAM contents;
// a monitor process compares them against the DUT whenever it presents an output.
module tb_dma_stream_responder;
  localparam int DW = 16, AW = 8, CW = 16, THR = 3, DEPTH = 256;
  localparam int CMAX = 65535;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, cfg_load, ld_we, rd_en, rd_en1, wr_en, ib_valid;
  logic [1:0]    cfg_mode;
  logic [AW-1:0] cfg_base, cfg_window, cfg_wbase, ld_addr, dbg_addr;
  logic [DW-1:0] ld_data, ib_data;
  logic [DW-1:0] ob_data, dbg_data, ob_data1, dbg_data1;
  logic          ob_we, ib_re, ob_we1, ib_re1;
  logic [CW-1:0] rd_beats, wr_beats, rd_beats1, wr_beats1;
  logic          wr_en1 = 1'b0;

  dma_stream_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .THROTTLE(THR), .CNT_WIDTH(CW)) u_dut (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
    .cfg_window(cfg_window), .cfg_wbase(cfg_wbase), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_en(rd_en), .ob_data(ob_data), .ob_we(ob_we), .wr_en(wr_en),
    .ib_re(ib_re), .ib_data(ib_data), .ib_valid(ib_valid), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data), .rd_beats(rd_beats), .wr_beats(wr_beats));

  // Single-cycle-throttle instance sharing config and preload, with its own read enable.
  dma_stream_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .THROTTLE(1), .CNT_WIDTH(CW)) u_dut1 (
    .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_mode(cfg_mode), .cfg_base(cfg_base),
    .cfg_window(cfg_window), .cfg_wbase(cfg_wbase), .ld_we(ld_we), .ld_addr(ld_addr),
    .ld_data(ld_data), .rd_en(rd_en1), .ob_data(ob_data1), .ob_we(ob_we1), .wr_en(wr_en1),
    .ib_re(ib_re1), .ib_data(ib_data), .ib_valid(ib_valid), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data1), .rd_beats(rd_beats1), .wr_beats(wr_beats1));

  int n_vec = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct { int edge_no; logic [DW-1:0] data; } beat_t;
  typedef struct { int edge_no; int rdb; int wrb; int rdb1; bit dbg_chk; logic [DW-1:0] dbg; } stat_t;
  beat_t q_rd0[$];
  beat_t q_rd1[$];
  int    q_re[$];
  stat_t q_st[$];

  // Reference model state: configuration plus event counts since the last load.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_res [DEPTH];
  bit            m_res_ok [DEPTH];
  int m_mode = 0, m_base = 0, m_win = 0, m_wbase = 0;
  int m_rcyc [2] = '{0, 0};
  int m_rk   [2] = '{0, 0};
  int m_wcyc = 0, m_wk = 0;
  bit m_re_now = 0;

  function automatic int beat_addr(int k);
    int w = (m_win == 0) ? DEPTH : m_win;
    case (m_mode)
      1:       return (m_base + k % w) % DEPTH;
      2:       return (m_base + k / w + k % w) % DEPTH;
      default: return (m_base + k) % DEPTH;
    endcase
  endfunction

  function automatic int sat(int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic report(input string name, input int act, input int exp);
    n_bad++;
    $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, edge_cnt);
  endtask

  // Evaluate the model for the inputs applied this cycle; expectations land after the next edge.
  task automatic model_step();
    int    nxt = edge_cnt + 1;
    stat_t s;
    beat_t b;
    bit    next_re = 0;
    s.edge_no = nxt;
    if (rst) begin
      m_mode = 0; m_base = 0; m_win = 0; m_wbase = 0;
      m_rcyc = '{0, 0}; m_rk = '{0, 0}; m_wcyc = 0; m_wk = 0; m_re_now = 0;
      s.dbg_chk = 1; s.dbg = '0;
    end else begin
      s.dbg_chk = m_res_ok[dbg_addr];
      s.dbg     = m_res[dbg_addr];
      if (cfg_load) begin
        m_mode = int'(cfg_mode); m_base = int'(cfg_base); m_win = int'(cfg_window);
        m_wbase = int'(cfg_wbase);
        m_rcyc = '{0, 0}; m_rk = '{0, 0}; m_wcyc = 0; m_wk = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          if ((i == 0) ? rd_en : rd_en1) begin
            m_rcyc[i]++;
            if (m_rcyc[i] % ((i == 0) ? THR : 1) == 0) begin
              b.edge_no = nxt;
              b.data    = m_mem[beat_addr(m_rk[i])];
              if (i == 0) q_rd0.push_back(b); else q_rd1.push_back(b);
              m_rk[i]++;
            end
          end
        end
        if (m_re_now && ib_valid) begin
          m_res[(m_wbase + m_wk) % DEPTH]    = ib_data;
          m_res_ok[(m_wbase + m_wk) % DEPTH] = 1;
          m_wk++;
        end
        if (wr_en) begin
          m_wcyc++;
          if (m_wcyc % THR == 0) begin
            next_re = 1;
            q_re.push_back(nxt);
          end
        end
      end
      m_re_now = next_re;
    end
    s.rdb = sat(m_rk[0]); s.wrb = sat(m_wk); s.rdb1 = sat(m_rk[1]);
    q_st.push_back(s);
    if (ld_we) m_mem[ld_addr] = ld_data;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    cfg_load = 1'b0;
    ld_we    = 1'b0;
  endtask

  task automatic load(input int mode, input int base, input int win, input int wbase);
    cfg_load = 1'b1; cfg_mode = 2'(mode); cfg_base = AW'(base);
    cfg_window = AW'(win); cfg_wbase = AW'(wbase);
    step();
  endtask

  // Monitor: pops expectations whenever the DUT strobes, and flags strobes that are late or absent.
  initial begin
    beat_t b;
    stat_t s;
    forever begin
      @(posedge clk);
      #1;
      if (ob_we) begin
        n_vec++;
        if (q_rd0.size() == 0) report("ob_we_unexpected", 1, 0);
        else begin
          b = q_rd0.pop_front();
          if (b.edge_no != edge_cnt) report("ob_we_timing", edge_cnt, b.edge_no);
          else if (ob_data !== b.data) report("ob_data", int'(ob_data), int'(b.data));
        end
      end else if (q_rd0.size() > 0 && q_rd0[0].edge_no <= edge_cnt) begin
        n_vec++;
        report("ob_we_missing", 0, 1);
        void'(q_rd0.pop_front());
      end
      if (ob_we1) begin
        n_vec++;
        if (q_rd1.size() == 0) report("ob_we1_unexpected", 1, 0);
        else begin
          b = q_rd1.pop_front();
          if (b.edge_no != edge_cnt) report("ob_we1_timing", edge_cnt, b.edge_no);
          else if (ob_data1 !== b.data) report("ob_data1", int'(ob_data1), int'(b.data));
        end
      end else if (q_rd1.size() > 0 && q_rd1[0].edge_no <= edge_cnt) begin
        n_vec++;
        report("ob_we1_missing", 0, 1);
        void'(q_rd1.pop_front());
      end
      if (ib_re) begin
        n_vec++;
        if (q_re.size() == 0) report("ib_re_unexpected", 1, 0);
        else if (q_re.pop_front() != edge_cnt) report("ib_re_timing", edge_cnt, 0);
      end else if (q_re.size() > 0 && q_re[0] <= edge_cnt) begin
        n_vec++;
        report("ib_re_missing", 0, 1);
        void'(q_re.pop_front());
      end
      if (ib_re1) begin
        n_vec++;
        report("ib_re1_unexpected", 1, 0);
      end
      while (q_st.size() > 0 && q_st[0].edge_no <= edge_cnt) begin
        s = q_st.pop_front();
        n_vec++;
        if (int'(rd_beats) != s.rdb) report("rd_beats", int'(rd_beats), s.rdb);
        else if (int'(wr_beats) != s.wrb) report("wr_beats", int'(wr_beats), s.wrb);
        else if (int'(rd_beats1) != s.rdb1) report("rd_beats1", int'(rd_beats1), s.rdb1);
        else if (s.dbg_chk && dbg_data !== s.dbg) report("dbg_data", int'(dbg_data), int'(s.dbg));
      end
    end
  end

  initial begin
    rst = 1'b1; cfg_load = 0; cfg_mode = 0; cfg_base = 0; cfg_window = 0; cfg_wbase = 0;
    ld_we = 0; ld_addr = 0; ld_data = 0; rd_en = 0; rd_en1 = 0; wr_en = 0;
    ib_valid = 0; ib_data = 0; dbg_addr = 0;
    for (int i = 0; i < DEPTH; i++) m_res_ok[i] = 0;
    @(negedge clk);
    repeat (3) step();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      ld_we = 1'b1; ld_addr = AW'(i); ld_data = DW'(16'h3000 + i);
      step();
    end

    // Wrap window of 4 at base 10: 300a..300d then back to 300a.
    load(1, 10, 4, 0);
    rd_en = 1; repeat (15) step();
    rd_en = 0; repeat (3) step();

    // Sliding window of 45 over 91 beats.
    load(2, 0, 45, 0);
    rd_en = 1; repeat (91 * THR) step();
    rd_en = 0; repeat (3) step();

    // Single-cycle throttle crossing the top of the address space.
    load(0, 254, 0, 0);
    rd_en1 = 1; repeat (4) step();
    rd_en1 = 0; repeat (2) step();

    // Write capture at wbase 5, then read back through the debug port.
    load(0, 0, 0, 5);
    wr_en = 1; ib_valid = 1;
    for (int c = 0; c < 11; c++) begin
      ib_data = DW'(16'h4400 + m_wk * 16'h0100);
      step();
    end
    wr_en = 0; ib_valid = 0;
    for (int a = 5; a < 8; a++) begin
      dbg_addr = AW'(a); step();
    end
    step();

    // Load landing on a firing read cycle cancels that beat and restarts from the new base.
    load(0, 20, 0, 0);
    rd_en = 1; repeat (THR - 1) step();
    load(0, 40, 0, 0);
    repeat (2 * THR + 1) step();

    // Reset in mid-stream, then a clean restart.
    repeat (THR - 1) step();
    rst = 1; step();
    rst = 0; repeat (2) step();
    load(1, 100, 3, 0);
    repeat (4 * THR) step();
    rd_en = 0; step();

    // Randomised traffic.
    for (int c = 0; c < 2000; c++) begin
      rd_en    = ($urandom_range(0, 9) < 7);
      rd_en1   = $urandom_range(0, 1) == 1;
      wr_en    = ($urandom_range(0, 9) < 6);
      ib_valid = $urandom_range(0, 3) != 0;
      ib_data  = DW'($urandom);
      dbg_addr = AW'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        ld_we   = 1;
        ld_addr = ($urandom_range(0, 3) == 0) ? AW'(beat_addr(m_rk[0])) : AW'($urandom);
        ld_data = DW'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 119) == 0) begin
        cfg_load   = 1;
        cfg_mode   = 2'($urandom_range(0, 3));
        cfg_base   = AW'($urandom);
        cfg_window = ($urandom_range(0, 3) == 0) ? AW'(0) : AW'($urandom_range(1, 20));
        cfg_wbase  = AW'($urandom);
      end
      step();
    end

    rst = 0; rd_en = 0; rd_en1 = 0; wr_en = 0; ib_valid = 0;
    repeat (6) step();
    @(posedge clk);
    #3;
    if (q_rd0.size() + q_rd1.size() + q_re.size() > 0) begin
      n_vec++;
      report("pending_expectations", q_rd0.size() + q_rd1.size() + q_re.size(), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
